// File: rtl/alu_sequencer.sv
// Program sequencer for the 8-bit accumulator ALU: holds a small program store and
// issues one instruction per clock from slot 0 until an END-flagged slot or the last slot.
module alu_sequencer #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [7:0]    alu_result,
    output logic [7:0]    instruction,
    output logic          alu_en,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [7:0]    result,
    output logic [AW:0]   instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   count_q;
    logic [7:0]    result_q;
    logic          done_q;
    logic          aborted_q;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    cur_instr;

    // Program store: not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign cur_instr = mem_q[pc_q];

    // Issue path: END flag and reserved bit are masked off towards the ALU.
    assign alu_en      = (state_q == S_RUN);
    assign instruction = (state_q == S_RUN) ? (cur_instr & 8'hCF) : 8'h00;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign result      = result_q;
    assign instr_count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            count_q   <= '0;
            result_q  <= 8'h00;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        pc_q    <= '0;
                        count_q <= '0;
                    end
                end
                S_RUN: begin
                    // The instruction on this edge executes even when aborting.
                    count_q <= count_q + (AW+1)'(1);
                    if (abort) begin
                        state_q   <= S_IDLE;
                        aborted_q <= 1'b1;
                    end else if (cur_instr[5] || (pc_q == AW'(DEPTH - 1))) begin
                        state_q <= S_DRAIN;
                    end else begin
                        pc_q <= pc_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end else begin
                        result_q <= alu_result;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural accumulator ALU attached.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'h0;
    logic [7:0] prog_data = 8'h00;
    logic [7:0] alu_result;
    logic [7:0] instruction;
    logic       alu_en;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] result;
    logic [4:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Subtraction program (8 - 3): as stored (reserved bit set in two slots) and as issued.
    logic [7:0] sub_prog [11];
    logic [7:0] sub_exp  [11];

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .alu_result  (alu_result),
        .instruction (instruction),
        .alu_en      (alu_en),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .result      (result),
        .instr_count (instr_count)
    );

    // Accumulator ALU: 00 add, 01 nand, 10 mov a,data, 11 swap.
    logic [7:0] alu_a = 8'h00;
    logic [7:0] alu_b = 8'h00;
    always @(posedge clk) begin
        if (alu_en) begin
            case (instruction[7:6])
                2'b00:   alu_a <= alu_a + alu_b;
                2'b01:   alu_a <= ~(alu_a & alu_b);
                2'b10:   alu_a <= {4'h0, instruction[3:0]};
                default: begin
                    alu_a <= alu_b;
                    alu_b <= alu_a;
                end
            endcase
        end
    end
    assign alu_result = alu_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_slot(input logic [3:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    // Runs an n-instruction program, checking each issue cycle, drain and completion.
    task automatic run_prog(input string tag, input int n, input bit sub, input bit skip_start,
                            input bit chain, input bit disturb);
        logic [7:0] exp_i;
        logic [7:0] exp_r;
        exp_r = sub ? 8'h05 : 8'h01;
        if (!skip_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            exp_i = sub ? sub_exp[i] : ((i == 0) ? 8'h81 : 8'h00);
            check({tag, "_en"}, 32'(alu_en), 32'd1);
            check({tag, "_ins"}, 32'(instruction), 32'(exp_i));
            if (disturb && i == 1) begin
                prog_we   = 1'b1;
                prog_addr = 4'h0;
                prog_data = 8'h8F;
                start     = 1'b1;
            end
            if (disturb && i == 2) begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_drain_en"}, 32'(alu_en), 32'd0);
        check({tag, "_drain_busy"}, 32'(busy), 32'd1);
        check({tag, "_drain_done"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        check({tag, "_count"}, 32'(instr_count), 32'(n));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        if (chain) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        sub_prog = '{8'h83, 8'hD0, 8'h80, 8'h00, 8'h50, 8'hC0, 8'h81, 8'h00, 8'hC0, 8'h88, 8'h20};
        sub_exp  = '{8'h83, 8'hC0, 8'h80, 8'h00, 8'h40, 8'hC0, 8'h81, 8'h00, 8'hC0, 8'h88, 8'h00};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(alu_en), 32'd0);
        check("rst_ins", 32'(instruction), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);

        // All 16 slots, no END flag: runs to the last slot without wrapping.
        write_slot(4'h0, 8'h81);
        for (int i = 1; i < 16; i++) write_slot(4'(i), 8'h00);
        run_prog("full16", 16, 1'b0, 1'b0, 1'b0, 1'b0);

        // Subtraction program with END on slot 10.
        for (int i = 0; i < 11; i++) write_slot(4'(i), sub_prog[i]);
        run_prog("sub", 11, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort in the 4th RUN cycle.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abt_run4_en", 32'(alu_en), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abt_pulse", 32'(aborted), 32'd1);
        check("abt_done", 32'(done), 32'd0);
        check("abt_busy", 32'(busy), 32'd0);
        check("abt_en", 32'(alu_en), 32'd0);
        check("abt_count", 32'(instr_count), 32'd4);
        check("abt_result", 32'(result), 32'h05);
        @(negedge clk);
        check("abt_pulse_end", 32'(aborted), 32'd0);
        check("abt_en_later", 32'(alu_en), 32'd0);

        // Write and second start while busy: both ignored.
        run_prog("busy_we", 11, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("no_extra_run", 32'(busy), 32'd0);
            @(negedge clk);
        end
        run_prog("store_kept", 11, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start in the done cycle.
        run_prog("b2b_first", 11, 1'b1, 1'b0, 1'b1, 1'b0);
        run_prog("b2b_second", 11, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_pre_en", 32'(alu_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_en", 32'(alu_en), 32'd0);
        check("mid_rst_ins", 32'(instruction), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_aborted", 32'(aborted), 32'd0);
        check("post_rst_count", 32'(instr_count), 32'd0);
        run_prog("after_rst", 11, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
